// File: rtl/algo_frame_monitor.sv
// -----------------------------------------------------------------------------
// algo_frame_monitor
//   Inline receiver/checker for the algorithm result stream. A frame is
//   HDR_WORDS header words, then CH_WORDS channel words, then RECON_WORDS
//   recon words (167 words of 32 bit by default). The Avalon-ST stream passes
//   through combinationally with zero latency, and the monitor never stalls it.
//   The monitor parses the framing and counts good and bad frames. It keeps a
//   snapshot of the header and recon words of the last good frame, which the
//   host reads through a small Avalon-MM CSR block.
//
//   Optional feature macro: FRAME_MON_CHECKSUM_EN
//     defined   -> chk (CSR 11) = XOR of the channel words of the last good frame
//     undefined -> no XOR logic, CSR 11 reads 0
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   data_in_*                ST sink (data/valid/empty/sop/eop), ready = to_udp_ready
//   to_udp_*                 ST source, combinational copy of the sink
//   csr_address/read/write   CSR word address and strobes
//   csr_writedata            CSR write data (addr 0 bit0 = clear counters)
//   csr_readdata             CSR read data, registered, read latency 1
//   frame_done               one-cycle pulse when a good frame is committed
//
// CSR map: 0 status {29'b0, state[1:0], in_frame}, 1 good_cnt, 2 err_len,
//          3 err_sop, 4-6 header[0..2], 7-10 recon[0..3], 11 chk, 12 last_len
// -----------------------------------------------------------------------------
module algo_frame_monitor #(
    parameter int HDR_WORDS   = 3,
    parameter int CH_WORDS    = 160,
    parameter int RECON_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in_data,
    output logic        data_in_ready,
    input  logic        data_in_valid,
    input  logic [1:0]  data_in_empty,
    input  logic        data_in_startofpacket,
    input  logic        data_in_endofpacket,
    output logic [31:0] to_udp_data,
    output logic        to_udp_valid,
    output logic [1:0]  to_udp_empty,
    output logic        to_udp_startofpacket,
    output logic        to_udp_endofpacket,
    input  logic        to_udp_ready,
    input  logic [3:0]  csr_address,
    input  logic        csr_read,
    output logic [31:0] csr_readdata,
    input  logic        csr_write,
    input  logic [31:0] csr_writedata,
    output logic        frame_done
);
    localparam int FRAME_LEN = HDR_WORDS + CH_WORDS + RECON_WORDS;
    localparam int WCNT_W    = $clog2(FRAME_LEN);

    // HDR/CH/RECON phases are all S_FRAME; the phase is implied by wcnt.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FRAME   = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t              state;
    logic [WCNT_W-1:0]   wcnt;
    logic [31:0]         hdr_sh [HDR_WORDS];
    logic [31:0]         rec_sh [RECON_WORDS];
    logic [31:0]         hdr_q  [HDR_WORDS];
    logic [31:0]         rec_q  [RECON_WORDS];
    logic [31:0]         good_cnt, err_len, err_sop, last_len;
`ifdef FRAME_MON_CHECKSUM_EN
    logic [31:0]         chk_run, chk_q;
`endif

    logic beat, sop, eop, at_last, in_frame, clr;
    logic sop_err, len_err, good_eop;

    // Zero-latency pass-through.
    assign to_udp_data          = data_in_data;
    assign to_udp_valid         = data_in_valid;
    assign to_udp_empty         = data_in_empty;
    assign to_udp_startofpacket = data_in_startofpacket;
    assign to_udp_endofpacket   = data_in_endofpacket;
    assign data_in_ready        = to_udp_ready;

    assign beat     = data_in_valid & to_udp_ready;
    assign sop      = data_in_startofpacket;
    assign eop      = data_in_endofpacket;
    assign at_last  = (wcnt == WCNT_W'(FRAME_LEN - 1));
    assign in_frame = (state == S_FRAME);
    assign clr      = csr_write && (csr_address == 4'd0) && csr_writedata[0];

    // Counter events for the current beat. An SOP always restarts a frame, so
    // SOP+EOP is an early EOP regardless of the previous state.
    always_comb begin
        sop_err  = 1'b0;
        len_err  = 1'b0;
        good_eop = 1'b0;
        if (beat) begin
            if (sop) begin
                sop_err = (state != S_IDLE);
                len_err = eop;
            end else if (state == S_IDLE) begin
                sop_err = 1'b1;
            end else if (state == S_FRAME) begin
                len_err  = (eop != at_last);
                good_eop = eop && at_last;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            wcnt       <= '0;
            frame_done <= 1'b0;
            good_cnt   <= '0;
            err_len    <= '0;
            err_sop    <= '0;
            last_len   <= '0;
            for (int i = 0; i < HDR_WORDS; i++) begin
                hdr_sh[i] <= '0;
                hdr_q[i]  <= '0;
            end
            for (int i = 0; i < RECON_WORDS; i++) begin
                rec_sh[i] <= '0;
                rec_q[i]  <= '0;
            end
`ifdef FRAME_MON_CHECKSUM_EN
            chk_run    <= '0;
            chk_q      <= '0;
`endif
        end else begin
            frame_done <= good_eop;

            // Commit one cycle after the good EOP beat. The shadow copy still
            // holds the finished frame even if a new SOP arrives this cycle.
            if (frame_done) begin
                hdr_q    <= hdr_sh;
                rec_q    <= rec_sh;
                last_len <= 32'(FRAME_LEN);
`ifdef FRAME_MON_CHECKSUM_EN
                chk_q    <= chk_run;
`endif
            end

            // A host clear beats any increment in the same cycle.
            if (clr)           good_cnt <= '0;
            else if (frame_done) good_cnt <= good_cnt + 32'd1;
            if (clr)           err_len <= '0;
            else if (len_err)  err_len <= err_len + 32'd1;
            if (clr)           err_sop <= '0;
            else if (sop_err)  err_sop <= err_sop + 32'd1;

            if (beat) begin
                if (sop) begin
                    hdr_sh[0] <= data_in_data;
`ifdef FRAME_MON_CHECKSUM_EN
                    chk_run   <= '0;
`endif
                    if (eop) begin
                        state    <= S_IDLE;
                        wcnt     <= '0;
                        last_len <= 32'd1;
                    end else begin
                        state <= S_FRAME;
                        wcnt  <= WCNT_W'(1);
                    end
                end else begin
                    case (state)
                        S_FRAME: begin
                            for (int i = 0; i < HDR_WORDS; i++)
                                if (wcnt == WCNT_W'(i)) hdr_sh[i] <= data_in_data;
                            for (int i = 0; i < RECON_WORDS; i++)
                                if (wcnt == WCNT_W'(HDR_WORDS + CH_WORDS + i)) rec_sh[i] <= data_in_data;
`ifdef FRAME_MON_CHECKSUM_EN
                            if (wcnt >= WCNT_W'(HDR_WORDS) && wcnt < WCNT_W'(HDR_WORDS + CH_WORDS))
                                chk_run <= chk_run ^ data_in_data;
`endif
                            if (eop) begin
                                state <= S_IDLE;
                                wcnt  <= '0;
                                if (!at_last) last_len <= 32'(wcnt) + 32'd1;
                            end else if (at_last) begin
                                state <= S_DISCARD;
                                wcnt  <= '0;
                            end else begin
                                wcnt <= wcnt + WCNT_W'(1);
                            end
                        end
                        S_DISCARD: begin
                            if (eop) state <= S_IDLE;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Registered CSR read; the data holds while csr_read is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csr_readdata <= '0;
        end else if (csr_read) begin
            case (csr_address)
                4'd0:    csr_readdata <= {29'b0, state, in_frame};
                4'd1:    csr_readdata <= good_cnt;
                4'd2:    csr_readdata <= err_len;
                4'd3:    csr_readdata <= err_sop;
                4'd4:    csr_readdata <= hdr_q[0];
                4'd5:    csr_readdata <= hdr_q[1];
                4'd6:    csr_readdata <= hdr_q[2];
                4'd7:    csr_readdata <= rec_q[0];
                4'd8:    csr_readdata <= rec_q[1];
                4'd9:    csr_readdata <= rec_q[2];
                4'd10:   csr_readdata <= rec_q[3];
`ifdef FRAME_MON_CHECKSUM_EN
                4'd11:   csr_readdata <= chk_q;
`endif
                4'd12:   csr_readdata <= last_len;
                default: csr_readdata <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_algo_frame_monitor.sv
module tb_algo_frame_monitor;
    localparam int FL = 167;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in_data;
    logic        data_in_ready;
    logic        data_in_valid;
    logic [1:0]  data_in_empty;
    logic        data_in_startofpacket;
    logic        data_in_endofpacket;
    logic [31:0] to_udp_data;
    logic        to_udp_valid;
    logic [1:0]  to_udp_empty;
    logic        to_udp_startofpacket;
    logic        to_udp_endofpacket;
    logic        to_udp_ready;
    logic [3:0]  csr_address;
    logic        csr_read;
    logic [31:0] csr_readdata;
    logic        csr_write;
    logic [31:0] csr_writedata;
    logic        frame_done;

    algo_frame_monitor dut (
        .clk(clk), .rst(rst),
        .data_in_data(data_in_data), .data_in_ready(data_in_ready),
        .data_in_valid(data_in_valid), .data_in_empty(data_in_empty),
        .data_in_startofpacket(data_in_startofpacket), .data_in_endofpacket(data_in_endofpacket),
        .to_udp_data(to_udp_data), .to_udp_valid(to_udp_valid), .to_udp_empty(to_udp_empty),
        .to_udp_startofpacket(to_udp_startofpacket), .to_udp_endofpacket(to_udp_endofpacket),
        .to_udp_ready(to_udp_ready),
        .csr_address(csr_address), .csr_read(csr_read), .csr_readdata(csr_readdata),
        .csr_write(csr_write), .csr_writedata(csr_writedata),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: frames are collected as whole word lists and judged by length.
    logic [31:0] mq[$];
    int          m_mode;      // 0 idle, 1 collecting, 2 discarding to EOP
    logic [31:0] m_good, m_errlen, m_errsop, m_lastlen, m_chk;
    logic [31:0] m_hdr[3];
    logic [31:0] m_rec[4];
    int          m_commits;   // good frames since start, never cleared

    logic [31:0] frm[$];      // frame under construction for stimulus
    logic [31:0] rd[16];
    logic        bp_mode, ready_tog;

    int   fd_pulses = 0;
    int   fd_double = 0;
    logic fd_prev   = 1'b0;
    always @(posedge clk) begin
        fd_prev <= frame_done;
        if (frame_done) fd_pulses <= fd_pulses + 1;
        if (frame_done && fd_prev) fd_double <= fd_double + 1;
    end

    task automatic model_reset();
        mq.delete();
        m_mode = 0; m_good = 0; m_errlen = 0; m_errsop = 0; m_lastlen = 0; m_chk = 0;
        for (int i = 0; i < 3; i++) m_hdr[i] = 0;
        for (int i = 0; i < 4; i++) m_rec[i] = 0;
    endtask

    task automatic model_beat(input logic [31:0] d, input logic s, input logic e);
        if (s) begin
            if (m_mode != 0) m_errsop++;
            mq.delete();
            mq.push_back(d);
            m_mode = 1;
            if (e) begin m_errlen++; m_lastlen = 1; m_mode = 0; end
        end else if (m_mode == 0) begin
            m_errsop++;
        end else if (m_mode == 2) begin
            if (e) m_mode = 0;
        end else begin
            mq.push_back(d);
            if (e) begin
                if (mq.size() == FL) begin
                    for (int i = 0; i < 3; i++) m_hdr[i] = mq[i];
                    for (int i = 0; i < 4; i++) m_rec[i] = mq[163 + i];
                    m_chk = 0;
                    for (int i = 3; i < 163; i++) m_chk = m_chk ^ mq[i];
                    m_good++; m_commits++; m_lastlen = FL;
                end else begin
                    m_errlen++; m_lastlen = mq.size();
                end
                m_mode = 0;
            end else if (mq.size() == FL) begin
                m_errlen++; m_mode = 2;
            end
        end
    endtask

    function automatic logic [31:0] exp_csr(input int a);
        case (a)
            0:  exp_csr = (m_mode == 1) ? 32'd3 : (m_mode == 2) ? 32'd4 : 32'd0;
            1:  exp_csr = m_good;
            2:  exp_csr = m_errlen;
            3:  exp_csr = m_errsop;
            4, 5, 6: exp_csr = m_hdr[a - 4];
            7, 8, 9, 10: exp_csr = m_rec[a - 7];
`ifdef FRAME_MON_CHECKSUM_EN
            11: exp_csr = m_chk;
`endif
            12: exp_csr = m_lastlen;
            default: exp_csr = 0;
        endcase
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    task automatic beat(input logic [31:0] d, input logic s, input logic e);
        logic ok;
        ok = 1'b0;
        data_in_data = d; data_in_startofpacket = s; data_in_endofpacket = e;
        data_in_empty = 2'($urandom_range(0, 3)); data_in_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            to_udp_ready = bp_mode ? ready_tog : 1'b1;
            ready_tog = ~ready_tog;
            #1;
            n_cmp++;
            if (data_in_ready !== to_udp_ready || to_udp_data !== d || to_udp_valid !== 1'b1 ||
                to_udp_empty !== data_in_empty || to_udp_startofpacket !== s || to_udp_endofpacket !== e) begin
                n_err++;
                $display("FAIL passthru: rdy %b/%b data %h/%h sop %b eop %b empty %0d/%0d", data_in_ready,
                         to_udp_ready, to_udp_data, d, to_udp_startofpacket, to_udp_endofpacket, to_udp_empty, data_in_empty);
            end
            @(posedge clk); #1;
            if (to_udp_ready) begin ok = 1'b1; model_beat(d, s, e); break; end
        end
        data_in_valid = 1'b0; data_in_startofpacket = 1'b0; data_in_endofpacket = 1'b0;
        to_udp_ready = 1'b1;
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL beat_timeout: accepted 0 required 1"); end
    endtask

    // Sends frm[from..to-1]; SOP on index 0, EOP on the final element when eop_end.
    task automatic send_range(input int from, input int to, input logic eop_end, input logic gaps);
        for (int i = from; i < to; i++) begin
            if (gaps && $urandom_range(0, 7) == 0) idle(1);
            beat(frm[i], i == 0, eop_end && (i == frm.size() - 1));
        end
    endtask

    task automatic build_frame(input int len, input logic pattern);
        frm.delete();
        for (int i = 0; i < len; i++) begin
            if (!pattern)        frm.push_back($urandom);
            else if (i < 3)      frm.push_back(32'hA0 + i);
            else if (i < 163)    frm.push_back(32'(i - 2));
            else                 frm.push_back(32'hB0 + (i - 163));
        end
    endtask

    task automatic csr_rd(input int a, output logic [31:0] v);
        csr_address = 4'(a); csr_read = 1'b1;
        @(posedge clk); #1;
        csr_read = 1'b0;
        v = csr_readdata;
    endtask

    task automatic read_all();
        for (int a = 0; a < 16; a++) csr_rd(a, rd[a]);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b1;
        idle(3);
        n_cmp++;
        if (frame_done !== 1'b0 || csr_readdata !== 32'd0) begin
            n_err++; $display("FAIL reset_outputs: frame_done %b readdata %h required 0/0", frame_done, csr_readdata);
        end
        rst = 1'b0;
        model_reset();
        read_all();
        for (int a = 0; a < 16; a++) begin
            n_cmp++;
            if (rd[a] !== 32'd0) begin n_err++; $display("FAIL reset_csr[%0d]: got %h required 0", a, rd[a]); end
        end
        csr_rd(0, v);
        csr_address = 4'd1;
        idle(2);
        n_cmp++;
        if (csr_readdata !== v) begin n_err++; $display("FAIL read_hold: got %h required %h", csr_readdata, v); end
    endtask

    task automatic test_good_frame();
        int p0;
        p0 = fd_pulses;
        bp_mode = 1'b0;
        build_frame(FL, 1'b1);
        send_range(0, FL, 1'b1, 1'b0);
        idle(3);
        read_all();
        for (int a = 0; a < 16; a++) begin
            n_cmp++;
            if (rd[a] !== exp_csr(a)) begin n_err++; $display("FAIL good_csr[%0d]: got %h required %h", a, rd[a], exp_csr(a)); end
        end
        n_cmp++;
        if (rd[1] !== 32'd1 || rd[4] !== 32'hA0 || rd[10] !== 32'hB3 || rd[12] !== 32'd167) begin
            n_err++; $display("FAIL good_fixed: cnt %h h0 %h r3 %h len %h", rd[1], rd[4], rd[10], rd[12]);
        end
        n_cmp++;
`ifdef FRAME_MON_CHECKSUM_EN
        if (rd[11] !== 32'h000000A0) begin n_err++; $display("FAIL good_chk: got %h required a0", rd[11]); end
`else
        if (rd[11] !== 32'h0) begin n_err++; $display("FAIL good_chk: got %h required 0", rd[11]); end
`endif
        n_cmp++;
        if (fd_pulses - p0 !== 1) begin n_err++; $display("FAIL good_pulses: got %0d required 1", fd_pulses - p0); end
    endtask

    task automatic test_backpressure();
        bp_mode = 1'b1;
        build_frame(FL, 1'b0);
        send_range(0, FL, 1'b1, 1'b0);
        bp_mode = 1'b0;
        idle(3);
        read_all();
        for (int a = 0; a < 16; a++) begin
            n_cmp++;
            if (rd[a] !== exp_csr(a)) begin n_err++; $display("FAIL bp_csr[%0d]: got %h required %h", a, rd[a], exp_csr(a)); end
        end
    endtask

    task automatic test_early_eop();
        build_frame(101, 1'b0);
        send_range(0, 101, 1'b1, 1'b1);
        idle(3);
        read_all();
        for (int a = 0; a < 16; a++) begin
            n_cmp++;
            if (rd[a] !== exp_csr(a)) begin n_err++; $display("FAIL early_csr[%0d]: got %h required %h", a, rd[a], exp_csr(a)); end
        end
        n_cmp++;
        if (rd[12] !== 32'd101) begin n_err++; $display("FAIL early_len: got %0d required 101", rd[12]); end
        build_frame(FL, 1'b0);
        send_range(0, FL, 1'b1, 1'b1);
        idle(3);
        read_all();
        for (int a = 0; a < 16; a++) begin
            n_cmp++;
            if (rd[a] !== exp_csr(a)) begin n_err++; $display("FAIL early_next_csr[%0d]: got %h required %h", a, rd[a], exp_csr(a)); end
        end
    endtask

    task automatic test_sop_restart();
        build_frame(FL, 1'b0);
        send_range(0, 50, 1'b0, 1'b0);
        build_frame(FL, 1'b0);
        send_range(0, FL, 1'b1, 1'b0);
        idle(3);
        read_all();
        for (int a = 0; a < 16; a++) begin
            n_cmp++;
            if (rd[a] !== exp_csr(a)) begin n_err++; $display("FAIL restart_csr[%0d]: got %h required %h", a, rd[a], exp_csr(a)); end
        end
        n_cmp++;
        if (rd[4] !== frm[0] || rd[6] !== frm[2]) begin
            n_err++; $display("FAIL restart_hdr: got %h %h required %h %h", rd[4], rd[6], frm[0], frm[2]);
        end
    endtask

    task automatic test_missing_eop();
        logic [31:0] v;
        build_frame(180, 1'b0);
        send_range(0, 170, 1'b0, 1'b0);
        csr_rd(0, v);
        n_cmp++;
        if (v !== exp_csr(0) || v !== 32'd4) begin n_err++; $display("FAIL discard_status: got %h required 4", v); end
        send_range(170, 180, 1'b1, 1'b0);
        csr_rd(0, v);
        n_cmp++;
        if (v !== 32'd0) begin n_err++; $display("FAIL discard_idle: got %h required 0", v); end
        build_frame(FL, 1'b0);
        send_range(0, FL, 1'b1, 1'b0);
        idle(3);
        read_all();
        for (int a = 0; a < 16; a++) begin
            n_cmp++;
            if (rd[a] !== exp_csr(a)) begin n_err++; $display("FAIL missing_csr[%0d]: got %h required %h", a, rd[a], exp_csr(a)); end
        end
    endtask

    task automatic test_clear_on_commit();
        build_frame(FL, 1'b0);
        send_range(0, FL, 1'b1, 1'b0);
        n_cmp++;
        if (frame_done !== 1'b1) begin n_err++; $display("FAIL commit_pulse: got %b required 1", frame_done); end
        csr_address = 4'd0; csr_writedata = 32'd1; csr_write = 1'b1;
        @(posedge clk); #1;
        csr_write = 1'b0;
        m_good = 0; m_errlen = 0; m_errsop = 0;
        idle(2);
        read_all();
        for (int a = 0; a < 16; a++) begin
            n_cmp++;
            if (rd[a] !== exp_csr(a)) begin n_err++; $display("FAIL clear_csr[%0d]: got %h required %h", a, rd[a], exp_csr(a)); end
        end
        n_cmp++;
        if (rd[1] !== 32'd0) begin n_err++; $display("FAIL clear_good: got %0d required 0", rd[1]); end
    endtask

    task automatic test_reset_midframe();
        build_frame(FL, 1'b0);
        send_range(0, 80, 1'b0, 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        model_reset();
        build_frame(FL, 1'b0);
        send_range(0, FL, 1'b1, 1'b1);
        idle(3);
        read_all();
        for (int a = 0; a < 16; a++) begin
            n_cmp++;
            if (rd[a] !== exp_csr(a)) begin n_err++; $display("FAIL rstmid_csr[%0d]: got %h required %h", a, rd[a], exp_csr(a)); end
        end
        n_cmp++;
        if (rd[1] !== 32'd1) begin n_err++; $display("FAIL rstmid_good: got %0d required 1", rd[1]); end
    endtask

    task automatic test_random();
        int kind, len;
        for (int f = 0; f < 10; f++) begin
            bp_mode = ($urandom_range(0, 2) == 0);
            kind = $urandom_range(0, 4);
            case (kind)
                0: begin build_frame(FL, 1'b0); send_range(0, FL, 1'b1, 1'b1); end
                1: begin len = $urandom_range(1, FL - 1); build_frame(len, 1'b0); send_range(0, len, 1'b1, 1'b1); end
                2: begin
                    len = $urandom_range(2, FL - 1); build_frame(len, 1'b0); send_range(0, len, 1'b0, 1'b1);
                    build_frame(FL, 1'b0); send_range(0, FL, 1'b1, 1'b1);
                end
                3: begin len = $urandom_range(FL + 1, FL + 20); build_frame(len, 1'b0); send_range(0, len, 1'b1, 1'b1); end
                default: beat($urandom, 1'b0, 1'($urandom_range(0, 1)));
            endcase
        end
        bp_mode = 1'b0;
        idle(3);
        read_all();
        for (int a = 0; a < 16; a++) begin
            n_cmp++;
            if (rd[a] !== exp_csr(a)) begin n_err++; $display("FAIL random_csr[%0d]: got %h required %h", a, rd[a], exp_csr(a)); end
        end
        n_cmp++;
        if (fd_pulses !== m_commits || fd_double !== 0) begin
            n_err++; $display("FAIL frame_done_pulses: got %0d (double %0d) required %0d", fd_pulses, fd_double, m_commits);
        end
    endtask

    initial begin
        rst = 1'b1;
        data_in_data = '0; data_in_valid = 1'b0; data_in_empty = '0;
        data_in_startofpacket = 1'b0; data_in_endofpacket = 1'b0;
        to_udp_ready = 1'b1; csr_address = '0; csr_read = 1'b0;
        csr_write = 1'b0; csr_writedata = '0;
        bp_mode = 1'b0; ready_tog = 1'b1; m_commits = 0;
        model_reset();
        test_reset();
        test_good_frame();
        test_backpressure();
        test_early_eop();
        test_sop_restart();
        test_missing_eop();
        test_clear_on_commit();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
